mips_if_fetch: RTL and testbench
================================

// Module: mips_if_fetch
// PURPOSE
//   Instruction fetch stage; producer side of the IF->ID interface consumed by the decode stage.
//   - Generates the PC and issues requests to instruction memory.
//   - Predecodes each returned word for static next-PC prediction.
//   - Delivers {inst, pc, pc_incr, prdt_taken} through a 2-entry IF/ID queue with valid/ready.
//   - Redirected by later stages on jump resolution or misprediction.
// PARAMETERS
//   RESET_PC  32'h0000_0000  first fetch address after reset
//   BTFN_EN   1              1: predict backward bxx taken; 0: bxx always predicted not-taken
// PORTS
//   clk               in   1   clock
//   rst_n             in   1   asynchronous active-low reset
//   ifu_req_valid     out  1   imem request valid
//   ifu_req_ready     in   1   imem accepts request
//   ifu_req_addr      out  32  fetch address, bits[1:0] always 0
//   ifu_rsp_valid     in   1   imem response valid (always accepted)
//   ifu_rsp_inst      in   32  fetched instruction word
//   flush_valid       in   1   redirect from ID/EX
//   flush_pc          in   32  redirect target
//   if2id_valid       out  1   queue head valid
//   id2if_ready       in   1   ID accepts head (pop = if2id_valid & id2if_ready)
//   if2id_inst        out  32  head instruction
//   if2id_pc          out  32  head PC
//   if2id_pc_incr     out  32  head PC+4
//   if2id_prdt_taken  out  1   head was predicted taken
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - pc_q=RESET_PC, queue empty, out_cnt=0, drop=0.
//     - All outputs 0 except ifu_req_addr=RESET_PC.
//     - First request in first cycle after deassertion.
//   - Max one outstanding request (out_cnt in {0,1}). Request accepted on ifu_req_valid & ifu_req_ready.
//   - Issue condition: ifu_req_valid = ~flush_valid & (out_cnt==0 | ifu_rsp_valid) & (q_cnt+out_cnt-pop < 2).
//     - Issue in the same cycle as a response is allowed.
//     - ifu_req_addr = next_pc when ifu_rsp_valid, else pc_q.
//   - Once asserted, valid/addr are held stable until ready; only flush_valid may withdraw an unaccepted request.
//   - Response handling (ifu_rsp_valid & ~drop):
//     - Push {inst, pc_q_issued, pc_q_issued+4, taken}.
//     - pc_q <= next_pc.
//     - Push never finds the queue full, by the credit rule.
//   - Predecode of returned word w, pc = issued address, p4 = pc+4 (mod 2^32):
//     - w[31:26] in {000010,000011}: taken=1, next_pc={p4[31:28],w[25:0],2'b00}.
//     - w[31:29]==000 & w[28:26] in {001,100,101,110,111} & w[15] & BTFN_EN:
//       taken=1, next_pc = p4 + {{14{w[15]}},w[15:0],2'b00}.
//     - Otherwise: taken=0, next_pc=p4. jr/jalr never predicted.
//   - No architectural delay slot: predicted target is fetched directly after the bxx/j.
//   - Flush (highest priority):
//     - Queue cleared the same cycle (if2id_valid=0 next cycle).
//     - pc_q <= {flush_pc[31:2],2'b00}; no request issued in the flush cycle.
//     - If a request is outstanding (or accepted this cycle), set drop.
//     - The next response is discarded and clears drop; issue from pc_q is allowed in that same cycle.
//   - Flush coinciding with a response: the response is discarded, and drop is not set for it.
//   - Queue FIFO order:
//     - Head registered; simultaneous push+pop when full is legal (pop frees a slot first).
//     - Head outputs stable while if2id_valid & ~id2if_ready.
//   - Throughput: 1 inst/cycle with single-cycle imem, ready=1, no redirects.
//   - Address arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
// TESTING
//   - Reset release, imem 1-cycle, ready=1: requests 0,4,8,... on consecutive cycles;
//     if2id_pc follows, prdt_taken=0 for NOPs.
//   - Word at 0x40 = 0x08000100 (j): next request 0x400, if2id_prdt_taken=1 for pc 0x40.
//   - bne at 0x100 with imm 0xFFFE: next request 0x0FC, prdt_taken=1.
//     - Same with imm 0x0002: next request 0x104, prdt_taken=0.
//     - BTFN_EN=0, imm 0xFFFE: next request 0x104.
//   - id2if_ready=0 for 5 cycles: queue fills to 2, ifu_req_valid drops, head held;
//     release -> in-order drain, no loss or duplication.
//   - flush_valid with flush_pc=0x203 while a request is outstanding:
//     - Stale response dropped, next fetch 0x200, queue empty the cycle after flush.
//   - rst_n asserted mid-transfer with queue full: outputs 0 immediately; refetch from RESET_PC after release.

Source files
------------

// File: rtl/mips_if_fetch.sv
// MIPS instruction fetch stage: PC generation, imem request, static next-PC predecode
// and a 2-entry IF/ID queue feeding the decode stage.
module mips_if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter bit          BTFN_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_inst,
   input  logic        flush_valid,
   input  logic [31:0] flush_pc,
   output logic        if2id_valid,
   input  logic        id2if_ready,
   output logic [31:0] if2id_inst,
   output logic [31:0] if2id_pc,
   output logic [31:0] if2id_pc_incr,
   output logic        if2id_prdt_taken
);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc_incr;
      logic        taken;
   } ent_t;

   logic [31:0] pc_q, pc_d;
   logic        out_cnt_q, out_cnt_d;
   logic        drop_q, drop_d;
   logic [1:0]  q_cnt_q, q_cnt_d;
   ent_t        head_q, head_d;
   ent_t        tail_q, tail_d;

   logic [31:0] pc_p4;
   logic [31:0] br_off;
   logic [31:0] next_pc;
   logic        is_jmp;
   logic        is_br;
   logic        pd_taken;
   logic        rsp_acc;
   logic        rsp_use;
   logic        pop;
   logic        req_fire;
   logic [1:0]  used;
   logic [1:0]  cnt_after;
   ent_t        new_ent;
   logic        flush_lsb_unused;

   assign flush_lsb_unused = |flush_pc[1:0];

   // Static prediction: j/jal always taken, backward conditional branches taken when BTFN_EN.
   always_comb begin
      pc_p4    = pc_q + 32'd4;
      is_jmp   = (ifu_rsp_inst[31:27] == 5'b00001);
      is_br    = BTFN_EN && (ifu_rsp_inst[31:29] == 3'b000)
                 && ((ifu_rsp_inst[28:26] == 3'b001) || ifu_rsp_inst[28])
                 && ifu_rsp_inst[15];
      br_off   = {{14{ifu_rsp_inst[15]}}, ifu_rsp_inst[15:0], 2'b00};
      pd_taken = is_jmp | is_br;
      if (is_jmp) begin
         next_pc = {pc_p4[31:28], ifu_rsp_inst[25:0], 2'b00};
      end else if (is_br) begin
         next_pc = pc_p4 + br_off;
      end else begin
         next_pc = pc_p4;
      end
   end

   // A response is only meaningful while a request is outstanding; pc_q is its issued address.
   always_comb begin
      rsp_acc       = ifu_rsp_valid & out_cnt_q;
      rsp_use       = rsp_acc & ~drop_q & ~flush_valid;
      if2id_valid   = (q_cnt_q != 2'd0);
      pop           = if2id_valid & id2if_ready;
      used          = q_cnt_q + {1'b0, out_cnt_q} - {1'b0, pop};
      ifu_req_valid = rst_n & ~flush_valid & (~out_cnt_q | rsp_acc) & (used < 2'd2);
      ifu_req_addr  = rsp_use ? next_pc : pc_q;
      req_fire      = ifu_req_valid & ifu_req_ready;
   end

   always_comb begin
      pc_d      = pc_q;
      out_cnt_d = req_fire | (out_cnt_q & ~rsp_acc);
      drop_d    = drop_q;
      if (flush_valid) begin
         pc_d   = {flush_pc[31:2], 2'b00};
         drop_d = out_cnt_q & ~rsp_acc;
      end else begin
         if (rsp_use) begin
            pc_d = next_pc;
         end
         if (rsp_acc) begin
            drop_d = 1'b0;
         end
      end
   end

   // Pop shifts the tail into the head before a push lands in the first free slot.
   always_comb begin
      new_ent.inst    = ifu_rsp_inst;
      new_ent.pc      = pc_q;
      new_ent.pc_incr = pc_p4;
      new_ent.taken   = pd_taken;
      head_d          = head_q;
      tail_d          = tail_q;
      cnt_after       = q_cnt_q - {1'b0, pop};
      q_cnt_d         = q_cnt_q;
      if (flush_valid) begin
         q_cnt_d = 2'd0;
      end else begin
         if (pop) begin
            head_d = tail_q;
         end
         if (rsp_use) begin
            if (cnt_after == 2'd0) begin
               head_d = new_ent;
            end else begin
               tail_d = new_ent;
            end
         end
         q_cnt_d = cnt_after + {1'b0, rsp_use};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         out_cnt_q <= 1'b0;
         drop_q    <= 1'b0;
         q_cnt_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         out_cnt_q <= out_cnt_d;
         drop_q    <= drop_d;
         q_cnt_q   <= q_cnt_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
      end
   end

   always_comb begin
      if2id_inst       = head_q.inst;
      if2id_pc         = head_q.pc;
      if2id_pc_incr    = head_q.pc_incr;
      if2id_prdt_taken = head_q.taken;
   end

endmodule

// File: tb/tb_mips_if_fetch.sv
// Directed bench for mips_if_fetch: behavioural imem with configurable latency,
// logs of accepted requests and IF/ID pops, compared against hand-computed vectors.
module tb_mips_if_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_ready = 1'b1;
   logic        flush_valid = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        id_ready = 1'b1;

   logic        req_valid0, v0, tk0;
   logic [31:0] req_addr0, inst0, pc0, incr0;
   logic        rsp_valid0 = 1'b0;
   logic [31:0] rsp_inst0 = '0;

   logic        req_valid1, v1, tk1;
   logic [31:0] req_addr1, pc1, inst1_unused, incr1_unused;
   logic        rsp_valid1 = 1'b0;
   logic [31:0] rsp_inst1 = '0;

   logic [31:0] mem [logic [31:0]];
   int unsigned lat = 1;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [31:0] req_log0[$], pop_pc0[$], pop_inst0[$], pop_incr0[$];
   logic        pop_tk0[$];
   logic [31:0] req_log1[$], pop_pc1[$];
   logic        pop_tk1[$];

   logic        pend0 = 1'b0, pend1 = 1'b0;
   int unsigned wait0 = 0, wait1 = 0;
   logic [31:0] paddr0 = '0, paddr1 = '0;

   always #5 clk = ~clk;

   mips_if_fetch #(.RESET_PC(32'h0000_0000), .BTFN_EN(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(req_valid0), .ifu_req_ready(req_ready), .ifu_req_addr(req_addr0),
      .ifu_rsp_valid(rsp_valid0), .ifu_rsp_inst(rsp_inst0),
      .flush_valid(flush_valid), .flush_pc(flush_pc),
      .if2id_valid(v0), .id2if_ready(id_ready), .if2id_inst(inst0), .if2id_pc(pc0),
      .if2id_pc_incr(incr0), .if2id_prdt_taken(tk0)
   );

   mips_if_fetch #(.RESET_PC(32'h0000_0000), .BTFN_EN(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(req_valid1), .ifu_req_ready(req_ready), .ifu_req_addr(req_addr1),
      .ifu_rsp_valid(rsp_valid1), .ifu_rsp_inst(rsp_inst1),
      .flush_valid(flush_valid), .flush_pc(flush_pc),
      .if2id_valid(v1), .id2if_ready(id_ready), .if2id_inst(inst1_unused), .if2id_pc(pc1),
      .if2id_pc_incr(incr1_unused), .if2id_prdt_taken(tk1)
   );

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // imem responders: respond on a negedge, then sample the settled handshake 1 time unit later
   always @(negedge clk) begin
      rsp_valid0 = 1'b0;
      rsp_inst0  = '0;
      if (pend0 && rst_n) begin
         if (wait0 == 0) begin
            rsp_valid0 = 1'b1;
            rsp_inst0  = rd(paddr0);
            pend0      = 1'b0;
         end else begin
            wait0 = wait0 - 1;
         end
      end else begin
         pend0 = 1'b0;
      end
      #1;
      if (rst_n && req_valid0 && req_ready) begin
         pend0  = 1'b1;
         wait0  = lat - 1;
         paddr0 = req_addr0;
         req_log0.push_back(req_addr0);
      end
      if (rst_n && v0 && id_ready) begin
         pop_pc0.push_back(pc0);
         pop_inst0.push_back(inst0);
         pop_incr0.push_back(incr0);
         pop_tk0.push_back(tk0);
      end
   end

   always @(negedge clk) begin
      rsp_valid1 = 1'b0;
      rsp_inst1  = '0;
      if (pend1 && rst_n) begin
         if (wait1 == 0) begin
            rsp_valid1 = 1'b1;
            rsp_inst1  = rd(paddr1);
            pend1      = 1'b0;
         end else begin
            wait1 = wait1 - 1;
         end
      end else begin
         pend1 = 1'b0;
      end
      #1;
      if (rst_n && req_valid1 && req_ready) begin
         pend1  = 1'b1;
         wait1  = lat - 1;
         paddr1 = req_addr1;
         req_log1.push_back(req_addr1);
      end
      if (rst_n && v1 && id_ready) begin
         pop_pc1.push_back(pc1);
         pop_tk1.push_back(tk1);
      end
   end

   task automatic clear_logs();
      req_log0.delete(); pop_pc0.delete(); pop_inst0.delete(); pop_incr0.delete(); pop_tk0.delete();
      req_log1.delete(); pop_pc1.delete(); pop_tk1.delete();
   endtask

   // Leaves the caller at the release negedge with logs cleared.
   task automatic do_reset(input logic idr);
      @(negedge clk);
      rst_n = 1'b0; req_ready = 1'b1; flush_valid = 1'b0; flush_pc = '0; id_ready = idr;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (req_valid0 !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", req_valid0); end
      n_cmp++; if (req_addr0 !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr: got %h want 0", req_addr0); end
      n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL rst_if2id_valid: got %b want 0", v0); end
      n_cmp++; if ({inst0, pc0, incr0, tk0} !== 97'h0) begin n_bad++; $display("FAIL rst_head: got %h/%h/%h/%b want zeros", inst0, pc0, incr0, tk0); end
      n_cmp++; if (req_valid1 !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid1: got %b want 0", req_valid1); end
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      #2;
      n_cmp++; if (req_valid0 !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", req_valid0); end
      n_cmp++; if (req_addr0 !== 32'h0) begin n_bad++; $display("FAIL first_req_addr: got %h want 0", req_addr0); end
   endtask

   task automatic test_sequential();
      mem.delete(); lat = 1;
      do_reset(1'b1);
      repeat (8) @(negedge clk);
      #2;
      n_cmp++; if (req_log0.size() != 9) begin n_bad++; $display("FAIL seq_req_count: got %0d want 9", req_log0.size()); end
      n_cmp++; if (pop_pc0.size() != 7) begin n_bad++; $display("FAIL seq_pop_count: got %0d want 7", pop_pc0.size()); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (i >= req_log0.size() || req_log0[i] !== 32'(i * 4)) begin
            n_bad++; $display("FAIL seq_req[%0d]: got %h want %h", i, (i < req_log0.size()) ? req_log0[i] : 32'hx, 32'(i * 4));
         end
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (i >= pop_pc0.size() || pop_pc0[i] !== 32'(i * 4) || pop_incr0[i] !== 32'(i * 4 + 4)
             || pop_tk0[i] !== 1'b0 || pop_inst0[i] !== 32'h0) begin
            n_bad++; $display("FAIL seq_pop[%0d]: got pc %h want %h", i, (i < pop_pc0.size()) ? pop_pc0[i] : 32'hx, 32'(i * 4));
         end
      end
   endtask

   task automatic test_predict();
      logic [31:0] er0 [7], er1 [7], ep0 [6], ei0 [6], en0 [6];
      logic        et0 [6], et1 [5];
      er0 = '{32'h0, 32'h40, 32'h400, 32'h100, 32'hFC, 32'h100, 32'hFC};
      er1 = '{32'h0, 32'h40, 32'h400, 32'h100, 32'h104, 32'h108, 32'h10C};
      ep0 = '{32'h0, 32'h40, 32'h400, 32'h100, 32'hFC, 32'h100};
      ei0 = '{32'h08000010, 32'h08000100, 32'h0C000040, 32'h1400FFFE, 32'h00008000, 32'h1400FFFE};
      en0 = '{32'h4, 32'h44, 32'h404, 32'h104, 32'h100, 32'h104};
      et0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      et1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      mem.delete(); lat = 1;
      mem[32'h0]   = 32'h08000010;
      mem[32'h40]  = 32'h08000100;
      mem[32'h400] = 32'h0C000040;
      mem[32'h100] = 32'h1400FFFE;
      mem[32'hFC]  = 32'h00008000;
      do_reset(1'b1);
      repeat (9) @(negedge clk);
      #2;
      for (int i = 0; i < 7; i++) begin
         n_cmp++;
         if (i >= req_log0.size() || req_log0[i] !== er0[i]) begin
            n_bad++; $display("FAIL pred_req[%0d]: got %h want %h", i, (i < req_log0.size()) ? req_log0[i] : 32'hx, er0[i]);
         end
         n_cmp++;
         if (i >= req_log1.size() || req_log1[i] !== er1[i]) begin
            n_bad++; $display("FAIL nobtfn_req[%0d]: got %h want %h", i, (i < req_log1.size()) ? req_log1[i] : 32'hx, er1[i]);
         end
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (i >= pop_pc0.size() || pop_pc0[i] !== ep0[i] || pop_inst0[i] !== ei0[i]
             || pop_incr0[i] !== en0[i] || pop_tk0[i] !== et0[i]) begin
            n_bad++;
            $display("FAIL pred_pop[%0d]: got pc %h taken %b want pc %h taken %b", i,
                     (i < pop_pc0.size()) ? pop_pc0[i] : 32'hx, (i < pop_tk0.size()) ? pop_tk0[i] : 1'bx, ep0[i], et0[i]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= pop_pc1.size() || pop_pc1[i] !== er1[i] || pop_tk1[i] !== et1[i]) begin
            n_bad++;
            $display("FAIL nobtfn_pop[%0d]: got pc %h taken %b want pc %h taken %b", i,
                     (i < pop_pc1.size()) ? pop_pc1[i] : 32'hx, (i < pop_tk1.size()) ? pop_tk1[i] : 1'bx, er1[i], et1[i]);
         end
      end
   endtask

   task automatic test_fwd_branch();
      logic [31:0] er0 [7], er1 [7], ep0 [3];
      logic        et0 [3];
      er0 = '{32'h0, 32'h40, 32'h400, 32'h100, 32'h104, 32'hE8, 32'hEC};
      er1 = '{32'h0, 32'h40, 32'h400, 32'h100, 32'h104, 32'h108, 32'h10C};
      ep0 = '{32'h100, 32'h104, 32'hE8};
      et0 = '{1'b0, 1'b1, 1'b0};
      mem[32'h100] = 32'h14000002;
      mem[32'h104] = 32'h0401FFF8;
      lat = 1;
      do_reset(1'b1);
      repeat (9) @(negedge clk);
      #2;
      for (int i = 0; i < 7; i++) begin
         n_cmp++;
         if (i >= req_log0.size() || req_log0[i] !== er0[i]) begin
            n_bad++; $display("FAIL fwd_req[%0d]: got %h want %h", i, (i < req_log0.size()) ? req_log0[i] : 32'hx, er0[i]);
         end
         n_cmp++;
         if (i >= req_log1.size() || req_log1[i] !== er1[i]) begin
            n_bad++; $display("FAIL fwd_nobtfn_req[%0d]: got %h want %h", i, (i < req_log1.size()) ? req_log1[i] : 32'hx, er1[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i + 3 >= pop_pc0.size() || pop_pc0[i + 3] !== ep0[i] || pop_tk0[i + 3] !== et0[i]) begin
            n_bad++; $display("FAIL fwd_pop[%0d]: got pc %h want pc %h taken %b", i + 3,
                              (i + 3 < pop_pc0.size()) ? pop_pc0[i + 3] : 32'hx, ep0[i], et0[i]);
         end
      end
      n_cmp++;
      if (pop_tk1.size() < 5 || pop_tk1[4] !== 1'b0) begin
         n_bad++; $display("FAIL fwd_nobtfn_taken: got %b want 0", (pop_tk1.size() >= 5) ? pop_tk1[4] : 1'bx);
      end
   endtask

   task automatic test_backpressure();
      mem.delete(); lat = 1;
      do_reset(1'b0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         #2;
         if (i >= 3) begin
            n_cmp++;
            if (req_valid0 !== 1'b0 || v0 !== 1'b1 || pc0 !== 32'h0 || incr0 !== 32'h4) begin
               n_bad++; $display("FAIL bp_hold[%0d]: got req_valid %b valid %b pc %h want 0 1 00000000", i, req_valid0, v0, pc0);
            end
         end
      end
      n_cmp++; if (req_log0.size() != 2) begin n_bad++; $display("FAIL bp_req_count: got %0d want 2", req_log0.size()); end
      @(negedge clk);
      id_ready = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= pop_pc0.size() || pop_pc0[i] !== 32'(i * 4) || i >= req_log0.size() || req_log0[i] !== 32'(i * 4)) begin
            n_bad++; $display("FAIL bp_drain[%0d]: got pop %h want %h", i, (i < pop_pc0.size()) ? pop_pc0[i] : 32'hx, 32'(i * 4));
         end
      end
   endtask

   task automatic test_req_hold();
      mem.delete(); lat = 1;
      do_reset(1'b1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      req_ready = 1'b0;
      #2;
      n_cmp++; if (req_valid0 !== 1'b1 || req_addr0 !== 32'hC) begin n_bad++; $display("FAIL hold_c0: got %b %h want 1 0000000c", req_valid0, req_addr0); end
      @(negedge clk);
      #2;
      n_cmp++; if (req_valid0 !== 1'b1 || req_addr0 !== 32'hC) begin n_bad++; $display("FAIL hold_c1: got %b %h want 1 0000000c", req_valid0, req_addr0); end
      @(negedge clk);
      req_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= req_log0.size() || req_log0[i] !== 32'(i * 4)) begin
            n_bad++; $display("FAIL hold_req[%0d]: got %h want %h", i, (i < req_log0.size()) ? req_log0[i] : 32'hx, 32'(i * 4));
         end
      end
   endtask

   task automatic test_flush_stale();
      logic [31:0] er [4];
      er = '{32'h0, 32'h4, 32'h200, 32'h204};
      mem.delete(); lat = 2;
      do_reset(1'b0);
      repeat (3) @(negedge clk);
      flush_valid = 1'b1;
      flush_pc = 32'h203;
      #2;
      n_cmp++; if (req_valid0 !== 1'b0) begin n_bad++; $display("FAIL fl_req_in_flush: got %b want 0", req_valid0); end
      @(negedge clk);
      flush_valid = 1'b0;
      #2;
      n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL fl_queue_cleared: got %b want 0", v0); end
      n_cmp++; if (req_valid0 !== 1'b1 || req_addr0 !== 32'h200) begin n_bad++; $display("FAIL fl_refetch: got %b %h want 1 00000200", req_valid0, req_addr0); end
      repeat (3) @(negedge clk);
      #2;
      n_cmp++; if (v0 !== 1'b1 || pc0 !== 32'h200 || incr0 !== 32'h204) begin n_bad++; $display("FAIL fl_head: got %b %h want 1 00000200", v0, pc0); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= req_log0.size() || req_log0[i] !== er[i]) begin
            n_bad++; $display("FAIL fl_req[%0d]: got %h want %h", i, (i < req_log0.size()) ? req_log0[i] : 32'hx, er[i]);
         end
      end
      lat = 1;
   endtask

   task automatic test_flush_rsp();
      mem.delete(); lat = 1;
      do_reset(1'b1);
      repeat (3) @(negedge clk);
      flush_valid = 1'b1;
      flush_pc = 32'h300;
      #2;
      n_cmp++; if (req_valid0 !== 1'b0) begin n_bad++; $display("FAIL flr_req_in_flush: got %b want 0", req_valid0); end
      @(negedge clk);
      flush_valid = 1'b0;
      #2;
      n_cmp++; if (v0 !== 1'b0 || req_valid0 !== 1'b1 || req_addr0 !== 32'h300) begin
         n_bad++; $display("FAIL flr_refetch: got valid %b req %b %h want 0 1 00000300", v0, req_valid0, req_addr0);
      end
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (v0 !== 1'b1 || pc0 !== 32'h300) begin n_bad++; $display("FAIL flr_head: got %b %h want 1 00000300", v0, pc0); end
   endtask

   task automatic test_wrap();
      mem.delete(); lat = 1;
      do_reset(1'b1);
      flush_valid = 1'b1;
      flush_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      flush_valid = 1'b0;
      #2;
      n_cmp++; if (req_valid0 !== 1'b1 || req_addr0 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req0: got %b %h want 1 fffffffc", req_valid0, req_addr0); end
      @(negedge clk);
      #2;
      n_cmp++; if (req_valid0 !== 1'b1 || req_addr0 !== 32'h0) begin n_bad++; $display("FAIL wrap_req1: got %b %h want 1 00000000", req_valid0, req_addr0); end
      @(negedge clk);
      #2;
      n_cmp++; if (v0 !== 1'b1 || pc0 !== 32'hFFFF_FFFC || incr0 !== 32'h0) begin
         n_bad++; $display("FAIL wrap_head: got %b %h %h want 1 fffffffc 00000000", v0, pc0, incr0);
      end
   endtask

   task automatic test_midreset();
      mem.delete(); lat = 1;
      mem[32'h0] = 32'h24080001;
      do_reset(1'b0);
      repeat (4) @(negedge clk);
      #2;
      n_cmp++; if (v0 !== 1'b1 || inst0 !== 32'h24080001 || req_addr0 !== 32'h8) begin
         n_bad++; $display("FAIL mr_pre: got %b %h %h want 1 24080001 00000008", v0, inst0, req_addr0);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (req_valid0 !== 1'b0 || req_addr0 !== 32'h0 || v0 !== 1'b0 || {inst0, pc0, incr0, tk0} !== 97'h0) begin
         n_bad++; $display("FAIL mr_async: got req %b %h valid %b inst %h pc %h want zeros", req_valid0, req_addr0, v0, inst0, pc0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      id_ready = 1'b1;
      clear_logs();
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (req_log0.size() < 1 || req_log0[0] !== 32'h0) begin n_bad++; $display("FAIL mr_refetch: got %h want 00000000", (req_log0.size() > 0) ? req_log0[0] : 32'hx); end
      n_cmp++; if (pop_pc0.size() != 1 || pop_inst0[0] !== 32'h24080001) begin n_bad++; $display("FAIL mr_pop: got %0d pops want 1 of 24080001", pop_pc0.size()); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_predict();
      test_fwd_branch();
      test_backpressure();
      test_req_hold();
      test_flush_stale();
      test_flush_rsp();
      test_wrap();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
